breakout_game_ctrl: RTL and testbench
=====================================

Name: breakout_game_ctrl

Overview:
Top-level game-flow controller for the breakout display. It consumes the graphics engine's single-cycle hit/miss pulses and produces the gra_still hold that freezes or recentres the ball and paddle. It also maintains the BCD score and remaining lives for the text overlay, and sequences the new-game, play, new-ball and game-over phases. Refresh timing is derived from the same pixel coordinates the graphics engine uses.

Parameters:
NUM_LIVES, 3, lives at game start (1..3).
TIMER_TICKS, 120, refresh ticks for the game-over and new-ball hold (2 s at 60 Hz; max 255).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
btn  in  5  push buttons; any nonzero value counts as a press
pix_x  in  10  current pixel column from the sync generator
pix_y  in  10  current pixel row from the sync generator
hit  in  1  one-cycle pulse from graphics: brick or paddle hit
miss  in  1  one-cycle pulse from graphics: ball lost
gra_still  out  1  1 holds the graphics at initial ball/paddle position
game_state  out  2  0=NEWGAME, 1=PLAY, 2=NEWBALL, 3=OVER
score_d1  out  4  BCD tens digit
score_d0  out  4  BCD units digit
lives  out  2  remaining balls
over_tick  out  1  one-cycle pulse on entry to OVER

Behaviour:
- All outputs are registered except gra_still, which decodes state: gra_still = (state != PLAY).
- Reset values: state NEWGAME, score 00, lives = NUM_LIVES, timer 0, over_tick 0, gra_still 1.
- refr_tick = (pix_y == 481) && (pix_x == 0). This is internal and lasts 1 cycle per frame.
- timer is an 8-bit down-counter.
  - Loads TIMER_TICKS on the cycle of entry to NEWBALL or OVER.
  - Decrements on refr_tick while nonzero; never wraps below 0.
  - timer_up = (timer == 0).
- NEWGAME:
  - Holds gra_still = 1.
  - On btn != 0: go to PLAY, clear score to 00, set lives = NUM_LIVES.
- PLAY:
  - hit: score increments by 1 in BCD. d0 wraps 9→0 and carries into d1. 99 → 00 with no flag.
  - miss with lives > 1: lives decrements, timer loads, go to NEWBALL.
  - miss with lives == 1: lives → 0, timer loads, over_tick = 1 for the next cycle only, go to OVER.
  - hit and miss in the same cycle: both take effect (score increments and the miss transition happens).
- NEWBALL: when timer_up and btn != 0, go to PLAY. A button pressed while the timer is nonzero is ignored.
- OVER:
  - When timer_up, go to NEWGAME.
  - Score and lives stay visible until the next game start.
- hit and miss are ignored in every state other than PLAY.
- Transition latency: state changes on the clock edge after the qualifying input. gra_still follows in the same cycle as the state.
- Reset mid-game returns to the reset values immediately (asynchronous). No pulse is emitted.
- Undefined state encoding is impossible (2 bits, 4 states). The default branch goes to NEWGAME.

Test Plan:
- Reset asserted, then released with btn = 0 for 1000 cycles → state 0, gra_still 1, score 00, lives 3, over_tick never 1.
- btn = 5'h01 for 1 cycle in NEWGAME, then 12 hit pulses → state 1, gra_still 0, score_d1 = 1, score_d0 = 2.
- Preload via 99 hits, then 1 more hit → score 00 and lives unchanged at 3.
- miss in PLAY with lives 3 → state 2, lives 2, gra_still 1. Press btn during the 120-tick hold: no change. After 120 refr_ticks, btn = 5'h10 → state 1.
- Three misses, each followed by a restart → on the third: lives 0, over_tick high for exactly 1 cycle, state 3. After 120 refr_ticks → state 0, score retained.
- hit and miss on the same cycle with lives 1 and score 05 → score 06, lives 0, state 3. Assert reset mid-OVER → state 0, score 00, lives 3 at once.

Source files
------------

// File: rtl/breakout_game_ctrl.sv
// breakout_game_ctrl: game-flow FSM, BCD score, lives and hold timer for the breakout display
// Ports: clk/reset (async, active-high); btn (any nonzero = press); pix_x/pix_y (sync generator position);
// hit/miss (one-cycle pulses from graphics); gra_still (hold graphics); game_state; score_d1/score_d0 (BCD);
// lives; over_tick (one-cycle pulse on entry to OVER).
module breakout_game_ctrl #(
    parameter int NUM_LIVES   = 3,
    parameter int TIMER_TICKS = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic [1:0] game_state,
    output logic [3:0] score_d1,
    output logic [3:0] score_d0,
    output logic [1:0] lives,
    output logic       over_tick
);
    localparam logic [1:0] NEWGAME = 2'd0, PLAY = 2'd1, NEWBALL = 2'd2, OVER = 2'd3;
    logic [1:0] state;
    logic [7:0] timer;
    logic       refr_tick, timer_up, pressed;
    // one cycle per frame, just below the visible area
    assign refr_tick  = (pix_y == 10'd481) && (pix_x == 10'd0);
    assign timer_up   = (timer == 8'd0);
    assign pressed    = (btn != 5'd0);
    assign gra_still  = (state != PLAY);
    assign game_state = state;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= NEWGAME;
            score_d1  <= 4'd0;
            score_d0  <= 4'd0;
            lives     <= 2'(NUM_LIVES);
            timer     <= 8'd0;
            over_tick <= 1'b0;
        end else begin
            over_tick <= 1'b0;
            if (refr_tick && !timer_up)
                timer <= timer - 8'd1;
            case (state)
                NEWGAME: if (pressed) begin
                    state    <= PLAY;
                    score_d1 <= 4'd0;
                    score_d0 <= 4'd0;
                    lives    <= 2'(NUM_LIVES);
                end
                PLAY: begin
                    if (hit) begin
                        score_d0 <= (score_d0 == 4'd9) ? 4'd0 : score_d0 + 4'd1;
                        if (score_d0 == 4'd9)
                            score_d1 <= (score_d1 == 4'd9) ? 4'd0 : score_d1 + 4'd1;
                    end
                    // a miss load overrides any same-cycle decrement
                    if (miss) begin
                        lives     <= lives - 2'd1;
                        timer     <= 8'(TIMER_TICKS);
                        over_tick <= (lives == 2'd1);
                        state     <= (lives == 2'd1) ? OVER : NEWBALL;
                    end
                end
                NEWBALL: if (timer_up && pressed) state <= PLAY;
                OVER:    if (timer_up) state <= NEWGAME;
                default: state <= NEWGAME;
            endcase
        end
    end
endmodule

// File: tb/tb_breakout_game_ctrl.sv
// tb_breakout_game_ctrl: directed stimulus with a behavioural model checked every cycle
module tb_breakout_game_ctrl;
    logic       clk = 1'b0, reset = 1'b1;
    logic [4:0] btn = 5'd0;
    logic [9:0] pix_x = 10'd0, pix_y = 10'd0;
    logic       hit = 1'b0, miss = 1'b0;
    logic       gra_still, over_tick;
    logic [1:0] game_state, lives;
    logic [3:0] score_d1, score_d0;
    int vectors = 0, errors = 0, n_over = 0;
    int m_state, m_score, m_lives, m_timer, m_over;

    breakout_game_ctrl dut (
        .clk(clk), .reset(reset), .btn(btn), .pix_x(pix_x), .pix_y(pix_y),
        .hit(hit), .miss(miss), .gra_still(gra_still), .game_state(game_state),
        .score_d1(score_d1), .score_d0(score_d0), .lives(lives), .over_tick(over_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // game rules at the level of whole numbers: score 0..99, lives count, frames left on the hold
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state <= 0; m_score <= 0; m_lives <= 3; m_timer <= 0; m_over <= 0;
        end else begin
            m_over <= 0;
            if (pix_y == 481 && pix_x == 0 && m_timer > 0) m_timer <= m_timer - 1;
            if (m_state == 0 && btn != 0) begin
                m_state <= 1; m_score <= 0; m_lives <= 3;
            end else if (m_state == 1) begin
                if (hit) m_score <= (m_score + 1) % 100;
                if (miss) begin
                    m_lives <= m_lives - 1;
                    m_timer <= 120;
                    m_over  <= (m_lives == 1);
                    m_state <= (m_lives == 1) ? 3 : 2;
                end
            end else if (m_state == 2 && m_timer == 0 && btn != 0) m_state <= 1;
            else if (m_state == 3 && m_timer == 0) m_state <= 0;
        end
    end

    always @(negedge clk) begin
        chk("state", game_state, m_state);
        chk("gra_still", gra_still, m_state != 1);
        chk("score_d1", score_d1, m_score / 10);
        chk("score_d0", score_d0, m_score % 10);
        chk("lives", lives, m_lives);
        chk("over_tick", over_tick, m_over);
        if (over_tick) n_over++;
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic hits(input int n);
        repeat (n) begin hit = 1'b1; step(); hit = 1'b0; step(); end
    endtask
    task automatic ticks(input int n);
        repeat (n) begin pix_y = 10'd481; step(); pix_y = 10'd0; step(); end
    endtask
    task automatic press(input logic [4:0] b);
        btn = b; step(); btn = 5'd0; step();
    endtask
    task automatic lose_ball;
        miss = 1'b1; step(); miss = 1'b0;
    endtask

    initial begin
        step(3);
        reset = 1'b0;
        step(1000);
        chk("idle_state", game_state, 0);
        chk("idle_still", gra_still, 1);
        chk("idle_lives", lives, 3);
        chk("idle_over_cnt", n_over, 0);
        press(5'h01);
        hits(12);
        chk("play_state", game_state, 1);
        chk("play_still", gra_still, 0);
        chk("score12_d1", score_d1, 1);
        chk("score12_d0", score_d0, 2);
        hits(87);
        chk("score99", {score_d1, score_d0}, 8'h99);
        hits(1);
        chk("score_wrap", {score_d1, score_d0}, 8'h00);
        chk("wrap_lives", lives, 3);
        lose_ball();
        chk("nb_state", game_state, 2);
        chk("nb_lives", lives, 2);
        chk("nb_still", gra_still, 1);
        hits(2);
        btn = 5'h04;
        ticks(119);
        pix_x = 10'd1; pix_y = 10'd481; step(); pix_x = 10'd0; pix_y = 10'd0;
        btn = 5'd0;
        chk("hold_btn_ignored", game_state, 2);
        chk("hold_hit_ignored", score_d0, 0);
        ticks(1);
        chk("hold_expired_no_btn", game_state, 2);
        press(5'h10);
        chk("restart_play", game_state, 1);
        hits(5);
        lose_ball();
        ticks(120);
        press(5'h02);
        chk("last_ball_lives", lives, 1);
        chk("score05", {score_d1, score_d0}, 8'h05);
        hit = 1'b1; miss = 1'b1; step(); hit = 1'b0; miss = 1'b0;
        chk("over_state", game_state, 3);
        chk("over_lives", lives, 0);
        chk("over_score", {score_d1, score_d0}, 8'h06);
        chk("over_tick_on", over_tick, 1);
        step();
        chk("over_tick_off", over_tick, 0);
        ticks(119);
        chk("over_hold", game_state, 3);
        ticks(1);
        step();
        chk("back_newgame", game_state, 0);
        chk("score_retained", {score_d1, score_d0}, 8'h06);
        chk("over_cnt1", n_over, 1);
        press(5'h08);
        chk("new_game_score", {score_d1, score_d0}, 8'h00);
        chk("new_game_lives", lives, 3);
        hits(3);
        repeat (2) begin lose_ball(); ticks(120); press(5'h01); end
        lose_ball();
        chk("over2_state", game_state, 3);
        step(4);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("rst_state", game_state, 0);
        chk("rst_score", {score_d1, score_d0}, 8'h00);
        chk("rst_lives", lives, 3);
        chk("rst_still", gra_still, 1);
        step(2);
        reset = 1'b0;
        step(5);
        chk("over_cnt2", n_over, 2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
